// File: rtl/wb_queue_if.sv
// Bundle between the execution units, the writeback queue and the register file.
// Queue side uses the slave modport; producers, register file and operand read use master.
interface wb_queue_if #(
  parameter int IN_PORTS    = 4,
  parameter int WRITE_PORTS = 4,
  parameter int READ_PORTS  = 4,
  parameter int DEPTH       = 8,
  parameter int ADDR_WIDTH  = 5,
  parameter int DATA_WIDTH  = 32
);
  // Handshake: a result group moves on a rising edge where in_ready=1; in_valid bits
  // seen while in_ready=0 are ignored, and the producer holds valid/addr/data until ready.
  logic [IN_PORTS-1:0]                     in_valid;
  logic [IN_PORTS-1:0][ADDR_WIDTH-1:0]     in_addr;
  logic [IN_PORTS-1:0][DATA_WIDTH-1:0]     in_data;
  logic                                    in_ready;
  logic [WRITE_PORTS-1:0]                  wr_enable;
  logic [WRITE_PORTS-1:0][ADDR_WIDTH-1:0]  wr_addr;
  logic [WRITE_PORTS-1:0][DATA_WIDTH-1:0]  wr_data;
  logic [READ_PORTS-1:0][ADDR_WIDTH-1:0]   lk_addr;
  logic [READ_PORTS-1:0]                   lk_hit;
  logic [READ_PORTS-1:0][DATA_WIDTH-1:0]   lk_data;
  logic [$clog2(DEPTH):0]                  count;

  modport master (
    output in_valid, in_addr, in_data, lk_addr,
    input  in_ready, wr_enable, wr_addr, wr_data, lk_hit, lk_data, count
  );

  modport slave (
    input  in_valid, in_addr, in_data, lk_addr,
    output in_ready, wr_enable, wr_addr, wr_data, lk_hit, lk_data, count
  );
endinterface

// File: rtl/wb_queue.sv
// Writeback queue: program-ordered circular FIFO of results feeding the register file
// write ports, with a bypass lookup of not-yet-written values.
module wb_queue #(
  parameter int IN_PORTS    = 4,
  parameter int WRITE_PORTS = 4,
  parameter int READ_PORTS  = 4,
  parameter int DEPTH       = 8,
  parameter int ADDR_WIDTH  = 5,
  parameter int DATA_WIDTH  = 32
) (
  input  logic        clock,
  input  logic        reset_n,
  wb_queue_if.slave   bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]                  head;
  logic [PTR_W-1:0]                  tail;
  logic [CNT_W-1:0]                  count;
  logic [ADDR_WIDTH-1:0]             ent_addr [DEPTH];
  logic [DATA_WIDTH-1:0]             ent_data [DEPTH];
  logic                              accept;
  logic [CNT_W-1:0]                  n_enq;
  logic [CNT_W-1:0]                  n_drain;
  logic [IN_PORTS-1:0]               keep;
  logic [IN_PORTS-1:0][PTR_W-1:0]    slot;

  // Readiness looks only at the registered count, so a drain in flight never helps.
  assign accept       = (count <= CNT_W'(DEPTH - IN_PORTS));
  assign bus.in_ready = accept;
  assign bus.count    = count;
  assign n_drain      = (count < CNT_W'(WRITE_PORTS)) ? count : CNT_W'(WRITE_PORTS);

  // Results to r0 are swallowed; the rest are packed in port order behind tail.
  always_comb begin
    n_enq = '0;
    keep  = '0;
    slot  = '0;
    for (int p = 0; p < IN_PORTS; p++) begin
      keep[p] = bus.in_valid[p] && (bus.in_addr[p] != '0);
      slot[p] = tail + PTR_W'(n_enq);
      if (keep[p]) n_enq = n_enq + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(n_drain);
      if (accept) tail <= tail + PTR_W'(n_enq);
      count <= count - n_drain + (accept ? n_enq : '0);
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      for (int p = 0; p < IN_PORTS; p++) begin
        if (keep[p]) begin
          ent_addr[slot[p]] <= bus.in_addr[p];
          ent_data[slot[p]] <= bus.in_data[p];
        end
      end
    end
  end

  // Oldest entries go out on the lowest ports so the register file's
  // highest-port-wins rule keeps the youngest value.
  always_comb begin
    bus.wr_enable = '0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    for (int i = 0; i < WRITE_PORTS; i++) begin
      bus.wr_enable[i] = (CNT_W'(i) < count);
      bus.wr_addr[i]   = ent_addr[head + PTR_W'(i)];
      bus.wr_data[i]   = ent_data[head + PTR_W'(i)];
    end
  end

  // Scan oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    bus.lk_hit  = '0;
    bus.lk_data = '0;
    for (int r = 0; r < READ_PORTS; r++) begin
      for (int k = 0; k < DEPTH; k++) begin
        if ((CNT_W'(k) < count) && (bus.lk_addr[r] != '0) &&
            (ent_addr[head + PTR_W'(k)] == bus.lk_addr[r])) begin
          bus.lk_hit[r]  = 1'b1;
          bus.lk_data[r] = ent_data[head + PTR_W'(k)];
        end
      end
    end
  end

  a_count_bound: assert property (@(posedge clock) disable iff (!reset_n)
    count <= CNT_W'(DEPTH));
endmodule

// File: tb/tb_wb_queue.sv
// Bench for wb_queue: a 4-write-port and a 2-write-port instance share one stimulus
// stream and are each compared every cycle against an ordered list of pending writes.
module tb_wb_queue;
  logic clock;
  logic reset_n;
  logic [3:0]        in_valid;
  logic [3:0][4:0]   in_addr;
  logic [3:0][31:0]  in_data;
  logic [3:0][4:0]   lk_addr;

  int checks = 0;
  int errors = 0;

  // Pending writes per instance, oldest first: {addr, data}
  logic [36:0] exp_qa[$];
  logic [36:0] exp_qb[$];

  wb_queue_if a_if ();
  wb_queue_if #(.WRITE_PORTS(2)) b_if ();

  assign a_if.in_valid = in_valid;
  assign a_if.in_addr  = in_addr;
  assign a_if.in_data  = in_data;
  assign a_if.lk_addr  = lk_addr;
  assign b_if.in_valid = in_valid;
  assign b_if.in_addr  = in_addr;
  assign b_if.in_data  = in_data;
  assign b_if.lk_addr  = lk_addr;

  wb_queue dut_a (.clock(clock), .reset_n(reset_n), .bus(a_if.slave));
  wb_queue #(.WRITE_PORTS(2)) dut_b (.clock(clock), .reset_n(reset_n), .bus(b_if.slave));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Called at a falling edge with inputs already driven: compare both DUTs with
  // the pending-write lists, advance the lists across the next rising edge.
  task automatic cycle();
    logic [36:0] q[$];
    int wp, n, sz;
    bit acc;
    logic [3:0] en, hit, cnt;
    logic [3:0][4:0] wa;
    logic [3:0][31:0] wd, ld;
    logic rdy, exp_hit;
    logic [31:0] exp_d;
    #1;
    for (int d = 0; d < 2; d++) begin
      wa = '0;
      wd = '0;
      if (d == 0) begin
        q = exp_qa; wp = 4;
        en = a_if.wr_enable; wa = a_if.wr_addr; wd = a_if.wr_data;
        rdy = a_if.in_ready; cnt = a_if.count; hit = a_if.lk_hit; ld = a_if.lk_data;
      end else begin
        q = exp_qb; wp = 2;
        en = {2'b00, b_if.wr_enable}; wa[1:0] = b_if.wr_addr; wd[1:0] = b_if.wr_data;
        rdy = b_if.in_ready; cnt = b_if.count; hit = b_if.lk_hit; ld = b_if.lk_data;
      end
      sz = q.size();
      checks++;
      if (cnt !== 4'(sz)) begin
        errors++; $display("FAIL count dut%0d got %0d exp %0d", d, cnt, sz);
      end
      acc = ((8 - sz) >= 4);
      checks++;
      if (rdy !== acc) begin
        errors++; $display("FAIL in_ready dut%0d got %0b exp %0b", d, rdy, acc);
      end
      for (int i = 0; i < wp; i++) begin
        checks++;
        if (en[i] !== (i < sz)) begin
          errors++; $display("FAIL wr_enable dut%0d port%0d got %0b exp %0b", d, i, en[i], i < sz);
        end
        if (i < sz) begin
          checks++;
          if (wa[i] !== q[i][36:32] || wd[i] !== q[i][31:0]) begin
            errors++;
            $display("FAIL wr_port dut%0d port%0d got %0d/%h exp %0d/%h",
                     d, i, wa[i], wd[i], q[i][36:32], q[i][31:0]);
          end
        end
      end
      for (int r = 0; r < 4; r++) begin
        exp_hit = 1'b0;
        exp_d = '0;
        foreach (q[k]) begin
          if (lk_addr[r] != 0 && q[k][36:32] == lk_addr[r]) begin
            exp_hit = 1'b1;
            exp_d = q[k][31:0];
          end
        end
        checks++;
        if (hit[r] !== exp_hit || ld[r] !== exp_d) begin
          errors++;
          $display("FAIL lookup dut%0d port%0d addr %0d got %0b/%h exp %0b/%h",
                   d, r, lk_addr[r], hit[r], ld[r], exp_hit, exp_d);
        end
      end
      n = (sz < wp) ? sz : wp;
      repeat (n) void'(q.pop_front());
      if (acc) begin
        for (int p = 0; p < 4; p++)
          if (in_valid[p] && in_addr[p] != 0) q.push_back({in_addr[p], in_data[p]});
      end
      if (d == 0) exp_qa = q; else exp_qb = q;
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic drain_all();
    in_valid = '0;
    for (int i = 0; i < 12 && (exp_qa.size() != 0 || exp_qb.size() != 0); i++) cycle();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    in_valid = '0; in_addr = '0; in_data = '0;
    lk_addr = {5'd4, 5'd3, 5'd2, 5'd1};
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    #1;
    checks++;
    if (a_if.count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", a_if.count); end
    checks++;
    if (a_if.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", a_if.in_ready); end
    checks++;
    if (a_if.wr_enable !== 4'b0000) begin errors++; $display("FAIL reset_wr_enable got %b exp 0000", a_if.wr_enable); end
    checks++;
    if (a_if.lk_hit !== 4'b0000) begin errors++; $display("FAIL reset_lk_hit got %b exp 0000", a_if.lk_hit); end
    lk_addr = '0;
    @(negedge clock);
  endtask

  task automatic test_basic();
    in_valid = 4'b1111;
    in_addr  = {5'd4, 5'd3, 5'd2, 5'd1};
    in_data  = {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
    cycle();
    in_valid = '0;
    #1;
    checks++;
    if (a_if.wr_enable !== 4'b1111) begin errors++; $display("FAIL basic_enable got %b exp 1111", a_if.wr_enable); end
    checks++;
    if (a_if.wr_addr !== {5'd4, 5'd3, 5'd2, 5'd1}) begin
      errors++; $display("FAIL basic_addr got %h exp %h", a_if.wr_addr, {5'd4, 5'd3, 5'd2, 5'd1});
    end
    checks++;
    if (a_if.wr_data !== {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001}) begin
      errors++; $display("FAIL basic_data got %h", a_if.wr_data);
    end
    cycle();
    checks++;
    if (a_if.count !== 4'd0) begin errors++; $display("FAIL basic_empty got %0d exp 0", a_if.count); end
    drain_all();
  endtask

  task automatic test_drop_r0();
    in_valid = 4'b1010;
    in_addr  = {5'd5, 5'd11, 5'd0, 5'd9};
    in_addr[1] = 5'd0;
    in_data  = {32'h5555_0005, 32'h0, 32'hEEEE_0000, 32'h0};
    cycle();
    in_valid = '0;
    #1;
    checks++;
    if (a_if.count !== 4'd1) begin errors++; $display("FAIL drop_count got %0d exp 1", a_if.count); end
    checks++;
    if (a_if.wr_enable !== 4'b0001) begin errors++; $display("FAIL drop_enable got %b exp 0001", a_if.wr_enable); end
    checks++;
    if (a_if.wr_addr[0] !== 5'd5) begin errors++; $display("FAIL drop_addr got %0d exp 5", a_if.wr_addr[0]); end
    drain_all();
  endtask

  task automatic test_same_addr();
    in_valid = 4'b0101;
    in_addr  = {5'd0, 5'd7, 5'd0, 5'd7};
    in_data  = {32'h0, 32'h2222_0007, 32'h0, 32'h1111_0007};
    lk_addr  = {5'd0, 5'd0, 5'd0, 5'd7};
    cycle();
    in_valid = '0;
    #1;
    checks++;
    if (a_if.wr_addr[0] !== 5'd7 || a_if.wr_addr[1] !== 5'd7) begin
      errors++; $display("FAIL same_addr got %0d,%0d exp 7,7", a_if.wr_addr[0], a_if.wr_addr[1]);
    end
    checks++;
    if (a_if.wr_data[1] !== 32'h2222_0007 || a_if.wr_data[0] !== 32'h1111_0007) begin
      errors++; $display("FAIL same_data got %h,%h exp 11110007,22220007", a_if.wr_data[0], a_if.wr_data[1]);
    end
    checks++;
    if (a_if.lk_hit[0] !== 1'b1 || a_if.lk_data[0] !== 32'h2222_0007) begin
      errors++; $display("FAIL same_lookup got %b/%h exp 1/22220007", a_if.lk_hit[0], a_if.lk_data[0]);
    end
    lk_addr = '0;
    drain_all();
  endtask

  task automatic test_back_to_back_wrap();
    bit got;
    int waited;
    for (int b = 0; b < 4; b++) begin
      in_valid = 4'b1111;
      for (int p = 0; p < 4; p++) begin
        in_addr[p] = 5'($urandom_range(1, 31));
        in_data[p] = $urandom;
      end
      waited = 0;
      got = 1'b0;
      while (!got && waited < 20) begin
        #1;
        got = b_if.in_ready;
        cycle();
        waited++;
      end
      checks++;
      if (!got) begin errors++; $display("FAIL wrap_accept burst%0d got timeout exp accept", b); end
      if (b == 0) begin
        checks++;
        if (b_if.count !== 4'd4) begin errors++; $display("FAIL wrap_count0 got %0d exp 4", b_if.count); end
      end
      if (b == 1) begin
        checks++;
        if (b_if.count !== 4'd6 || b_if.in_ready !== 1'b0) begin
          errors++; $display("FAIL wrap_full got %0d/%0b exp 6/0", b_if.count, b_if.in_ready);
        end
      end
    end
    drain_all();
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      in_valid = 4'($urandom);
      for (int p = 0; p < 4; p++) begin
        in_addr[p] = 5'($urandom_range(0, 7));
        in_data[p] = $urandom;
        lk_addr[p] = 5'($urandom_range(0, 7));
      end
      cycle();
    end
    lk_addr = '0;
    drain_all();
  endtask

  task automatic test_reset_mid();
    in_valid = 4'b1111;
    for (int p = 0; p < 4; p++) begin
      in_addr[p] = 5'($urandom_range(1, 31));
      in_data[p] = $urandom;
    end
    lk_addr = {5'd0, 5'd0, 5'd0, in_addr[3]};
    cycle();
    in_valid = 4'b0111;
    cycle();
    in_valid = '0;
    #1;
    checks++;
    if (b_if.count !== 4'd5) begin errors++; $display("FAIL mid_count got %0d exp 5", b_if.count); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (b_if.wr_enable !== 2'b00 || a_if.wr_enable !== 4'b0000) begin
      errors++; $display("FAIL mid_enable got %b/%b exp 00/0000", b_if.wr_enable, a_if.wr_enable);
    end
    checks++;
    if (b_if.count !== 4'd0 || b_if.in_ready !== 1'b1) begin
      errors++; $display("FAIL mid_flush got %0d/%0b exp 0/1", b_if.count, b_if.in_ready);
    end
    checks++;
    if (b_if.lk_hit !== 4'b0000) begin errors++; $display("FAIL mid_lookup got %b exp 0000", b_if.lk_hit); end
    exp_qa.delete();
    exp_qb.delete();
    @(negedge clock);
    reset_n = 1'b1;
    repeat (4) cycle();
    lk_addr = '0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_drop_r0();
    test_same_addr();
    test_back_to_back_wrap();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
